message_frame_parser: RTL

//  Downstream of the serial message receiver. Consumes its byte stream, delineates command frames,

---
 rtl/message_frame_parser.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/message_frame_parser.sv
// message_frame_parser
//   Delineates command frames in the byte stream coming from the serial
//   message receiver, checks the XOR checksum and hands the command, the
//   length and the 32-bit payload words to the register/control logic.
//   Frame: 0x55 0xAA CMD_H CMD_L LEN PAYLOAD[LEN] CHK
//   CHK  = CMD_H ^ CMD_L ^ LEN ^ payload bytes
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   msg_data_vld_i    byte strobe (one cycle per byte)
//   msg_data_i        received byte
//   cmd_vld_o         pulse: cmd_o / len_o updated
//   cmd_o, len_o      frame command (big-endian) and payload length
//   word_vld_o        pulse: word_o updated
//   word_o            payload word, first byte in [31:24]
//   frame_done_o      pulse at end or abort of a frame past the header
//   frame_ok_o        checksum result, held between pulses
//   frame_cnt_o       good frames (saturating)
//   err_cnt_o         bad frames (saturating)
module message_frame_parser #(
   parameter int MAX_LEN     = 64,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        msg_data_vld_i,
   input  logic [7:0]  msg_data_i,
   output logic        cmd_vld_o,
   output logic [15:0] cmd_o,
   output logic [7:0]  len_o,
   output logic        word_vld_o,
   output logic [31:0] word_o,
   output logic        frame_done_o,
   output logic        frame_ok_o,
   output logic [15:0] frame_cnt_o,
   output logic [15:0] err_cnt_o
);

   localparam int              GW        = $clog2(TIMEOUT_CYC);
   localparam logic [GW-1:0]   GAP_LAST  = GW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {IDLE, HDR1, CMD_H, CMD_L, LEN, PAYLOAD, CHK} state_t;

   state_t        state, state_nxt;
   logic [7:0]    chk;
   logic [15:0]   cmd_q;
   logic [7:0]    len_q;
   logic [7:0]    byte_cnt;
   logic [31:0]   word_acc, word_nxt;
   logic [GW-1:0] gap_cnt;

   logic vld, timeout, len_bad, last_byte, word_emit;
   logic cmd_vld_d, done_d, ok_d;

   assign vld       = msg_data_vld_i;
   // A byte in the timeout cycle wins; the timeout is only taken without one.
   assign timeout   = (state != IDLE) && !vld && (gap_cnt == GAP_LAST);
   assign len_bad   = msg_data_i > MAX_LEN_B;
   assign last_byte = (byte_cnt + 8'd1) == len_q;
   assign word_emit = (byte_cnt[1:0] == 2'd3) || last_byte;

   // Payload byte placed by its position in the word; a new word starts
   // from zero so a short final word has 0x00 in the unused low bytes.
   always_comb begin
      word_nxt = (byte_cnt[1:0] == 2'd0) ? 32'h0 : word_acc;
      case (byte_cnt[1:0])
         2'd0:    word_nxt[31:24] = msg_data_i;
         2'd1:    word_nxt[23:16] = msg_data_i;
         2'd2:    word_nxt[15:8]  = msg_data_i;
         default: word_nxt[7:0]   = msg_data_i;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state
   always_comb begin
      state_nxt = state;
      if (vld) begin
         case (state)
            IDLE:    if (msg_data_i == 8'h55) state_nxt = HDR1;
            HDR1:    if (msg_data_i == 8'hAA)      state_nxt = CMD_H;
                     else if (msg_data_i != 8'h55) state_nxt = IDLE;
            CMD_H:   state_nxt = CMD_L;
            CMD_L:   state_nxt = LEN;
            LEN:     if (len_bad)                  state_nxt = IDLE;
                     else if (msg_data_i == 8'h00) state_nxt = CHK;
                     else                          state_nxt = PAYLOAD;
            PAYLOAD: if (last_byte) state_nxt = CHK;
            CHK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end else if (timeout) begin
         state_nxt = IDLE;
      end
   end

   // Output decode (values registered below)
   always_comb begin
      cmd_vld_d = 1'b0;
      done_d    = 1'b0;
      ok_d      = 1'b0;
      if (vld) begin
         case (state)
            LEN: begin
               cmd_vld_d = !len_bad;
               done_d    = len_bad;
            end
            CHK: begin
               done_d = 1'b1;
               ok_d   = (msg_data_i == chk);
            end
            default: ;
         endcase
      end else if (timeout && state != HDR1) begin
         // abort from HDR1 is silent: no frame was opened yet
         done_d = 1'b1;
      end
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk          <= '0;
         cmd_q        <= '0;
         len_q        <= '0;
         byte_cnt     <= '0;
         word_acc     <= '0;
         gap_cnt      <= '0;
         cmd_vld_o    <= 1'b0;
         cmd_o        <= '0;
         len_o        <= '0;
         word_vld_o   <= 1'b0;
         word_o       <= '0;
         frame_done_o <= 1'b0;
         frame_ok_o   <= 1'b0;
         frame_cnt_o  <= '0;
         err_cnt_o    <= '0;
      end else begin
         cmd_vld_o    <= cmd_vld_d;
         word_vld_o   <= 1'b0;
         frame_done_o <= done_d;

         if (vld || timeout || state == IDLE) gap_cnt <= '0;
         else                                 gap_cnt <= gap_cnt + 1'b1;

         if (vld) begin
            case (state)
               CMD_H: begin
                  cmd_q[15:8] <= msg_data_i;
                  chk         <= msg_data_i;
               end
               CMD_L: begin
                  cmd_q[7:0] <= msg_data_i;
                  chk        <= chk ^ msg_data_i;
               end
               LEN: begin
                  chk      <= chk ^ msg_data_i;
                  len_q    <= msg_data_i;
                  byte_cnt <= '0;
                  if (!len_bad) begin
                     cmd_o <= cmd_q;
                     len_o <= msg_data_i;
                  end
               end
               PAYLOAD: begin
                  chk      <= chk ^ msg_data_i;
                  byte_cnt <= byte_cnt + 8'd1;
                  word_acc <= word_nxt;
                  if (word_emit) begin
                     word_vld_o <= 1'b1;
                     word_o     <= word_nxt;
                  end
               end
               default: ;
            endcase
         end

         if (done_d) begin
            frame_ok_o <= ok_d;
            if (ok_d) begin
               if (frame_cnt_o != 16'hFFFF) frame_cnt_o <= frame_cnt_o + 16'd1;
            end else begin
               if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
            end
         end
      end
   end

endmodule
